// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: architectural widths, reset PC, instruction size
// and the RUN/FLUSH state encoding used by the fetch controller.
package fetch_stage_pkg;

    localparam int          CPU_XLEN     = 32;
    localparam logic [31:0] CPU_RESET_PC = 32'h0000_0000;
    localparam int          INSN_BYTES   = 4;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_fifo.sv
// Small synchronous FIFO with push/pop/flush and an occupancy count.
// When empty, head_data keeps showing the last word popped so downstream
// outputs hold steady instead of exposing stale storage.
module fetch_stage_fifo
    import fetch_stage_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [WIDTH-1:0] last_q;
    logic             do_pop;
    logic             do_push;

    assign do_pop    = pop && (count != '0);
    assign do_push   = push && ((count != FULL) || do_pop);
    assign head_data = (count != '0) ? mem[rd_ptr] : last_q;

    // Storage, pointers and count; flush empties the queue but keeps the last popped word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            last_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                last_q <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues in-order fetches under a credit
// limit, tags responses with their PC and buffers them for decode. A redirect
// flushes all buffered work and counts outstanding responses to be dropped.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              XLEN       = CPU_XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = CPU_RESET_PC,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instruction,
    output logic [XLEN-1:0] id_pc
);

    localparam int              CW         = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0]     DEPTH_W    = (CW+1)'(FIFO_DEPTH);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INSN_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INSN_BYTES - 1);

    logic [XLEN-1:0]   pc_q;
    logic [CW-1:0]     inflight_q;
    logic [CW-1:0]     drop_q;
    fetch_state_e      state_q;

    logic [CW-1:0]     id_count;
    logic [CW-1:0]     tag_count;
    logic [XLEN-1:0]   tag_head;
    logic [2*XLEN-1:0] id_head;

    logic [CW:0]       occupancy;
    logic [CW-1:0]     inflight_less;
    logic              req_accept;
    logic              resp_keep;
    logic              id_pop;

    assign occupancy      = {1'b0, inflight_q} + {1'b0, id_count};
    assign imem_req_valid = !rst && !redirect_valid && (occupancy < DEPTH_W);
    assign imem_req_addr  = pc_q;
    assign req_accept     = imem_req_valid && imem_req_ready;
    assign inflight_less  = inflight_q - CW'(imem_resp_valid);
    assign resp_keep      = imem_resp_valid && !redirect_valid && (state_q == ST_RUN);
    assign id_valid       = (id_count != '0);
    assign id_pop         = id_valid && id_ready && !redirect_valid;
    assign {id_instruction, id_pc} = id_head;

    fetch_stage_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_insn_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (resp_keep),
        .push_data ({imem_resp_data, tag_head}),
        .pop       (id_pop),
        .flush     (redirect_valid),
        .head_data (id_head),
        .count     (id_count)
    );

    fetch_stage_fifo #(
        .WIDTH (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_accept),
        .push_data (pc_q),
        .pop       (resp_keep),
        .flush     (redirect_valid),
        .head_data (tag_head),
        .count     (tag_count)
    );

    // Program counter: redirect wins, otherwise advance one word per accepted fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q <= redirect_pc & ALIGN_MASK;
        end else if (req_accept) begin
            pc_q <= pc_q + PC_STEP;
        end
    end

    // Outstanding/drop counters and the RUN/FLUSH controller that discards stale responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= '0;
            drop_q     <= '0;
            state_q    <= ST_RUN;
        end else if (redirect_valid) begin
            inflight_q <= inflight_less;
            drop_q     <= inflight_less;
            state_q    <= (inflight_less != '0) ? ST_FLUSH : ST_RUN;
        end else begin
            inflight_q <= inflight_q + CW'(req_accept) - CW'(imem_resp_valid);
            if (imem_resp_valid && (state_q == ST_FLUSH)) begin
                drop_q <= drop_q - CW'(1);
                if (drop_q == CW'(1)) begin
                    state_q <= ST_RUN;
                end
            end
        end
    end

    resp_has_credit: assert property (@(posedge clk) disable iff (rst)
        imem_resp_valid |-> (inflight_q != '0));

    resp_has_tag: assert property (@(posedge clk) disable iff (rst)
        resp_keep |-> (tag_count != '0));

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised scoreboard bench for fetch_stage with an in-order memory model,
// plus directed scenarios for fill latency, backpressure, redirects, PC wrap and reset.
module tb_fetch_stage;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_ready = 1'b0;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_ready = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        id_valid;
    logic [31:0] id_instruction;
    logic [31:0] id_pc;

    fetch_stage #(
        .XLEN       (32),
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_instruction  (id_instruction),
        .id_pc           (id_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        int          epoch;
        int          ready_cyc;
    } mem_req_t;

    typedef struct {
        logic [31:0] insn;
        logic [31:0] pc;
    } id_item_t;

    mem_req_t    mem_q[$];
    mem_req_t    cur_resp;
    mem_req_t    new_req;
    id_item_t    sb[$];
    id_item_t    sb_item;
    logic [31:0] wrap_q[$];
    logic [31:0] model_pc = RESET_PC;
    logic [31:0] first_pc_exp = '0;
    int          cyc = 0;
    int          epoch = 0;
    int          model_inflight = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          first_acc_cyc = -1;
    int          first_idv_cyc = -1;
    bit          want_first = 1'b0;
    bit          wrap_capture = 1'b0;
    bit          exp_req;

    // Instruction memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Drive one cycle of inputs; memory answers in order no earlier than one cycle after accept.
    task automatic apply_stimulus(input bit do_rst, input int redir_mode, input logic [31:0] rpc,
                                  input int rdy_pct, input int idr_pct, input int resp_pct,
                                  output bit fired);
        @(posedge clk);
        #1;
        fired           = 1'b0;
        rst             = do_rst;
        redirect_valid  = 1'b0;
        redirect_pc     = rpc;
        imem_req_ready  = (int'($urandom_range(0, 99)) < rdy_pct);
        id_ready        = (int'($urandom_range(0, 99)) < idr_pct);
        imem_resp_valid = 1'b0;
        if (!do_rst && (mem_q.size() != 0) && (mem_q[0].ready_cyc <= cyc)
            && (int'($urandom_range(0, 99)) < resp_pct)) begin
            cur_resp        = mem_q.pop_front();
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(cur_resp.addr);
        end
        if (!do_rst && ((redir_mode == 1) ||
            ((redir_mode == 2) && id_valid && id_ready && imem_resp_valid))) begin
            redirect_valid = 1'b1;
            fired          = 1'b1;
        end
    endtask

    task automatic run_cycles(input int n, input int rdy_pct, input int idr_pct, input int resp_pct);
        bit f;
        for (int i = 0; i < n; i++) begin
            apply_stimulus(1'b0, 0, 32'h0, rdy_pct, idr_pct, resp_pct, f);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model and monitor: decides what the coming edge must do and checks the DUT against it.
    always @(negedge clk) begin
        if (rst) begin
            check_output("req_valid_in_reset", 32'(imem_req_valid), 32'd0);
            sb.delete();
            mem_q.delete();
            model_inflight = 0;
            model_pc       = RESET_PC;
            epoch++;
            want_first     = 1'b0;
            first_acc_cyc  = -1;
            first_idv_cyc  = -1;
        end else begin
            exp_req = !redirect_valid && ((model_inflight + sb.size()) < DEPTH);
            check_output("id_valid", 32'(id_valid), 32'(sb.size() != 0));
            check_output("req_valid", 32'(imem_req_valid), 32'(exp_req));
            if (id_valid && (first_idv_cyc < 0)) first_idv_cyc = cyc;
            if (redirect_valid) begin
                if (imem_resp_valid) model_inflight--;
                sb.delete();
                epoch++;
                model_pc = redirect_pc & 32'hFFFF_FFFC;
            end else begin
                if (id_valid && id_ready && (sb.size() != 0)) begin
                    sb_item = sb.pop_front();
                    check_output("id_pc", id_pc, sb_item.pc);
                    check_output("id_instruction", id_instruction, sb_item.insn);
                    if (want_first) begin
                        check_output("first_pc_after_redirect", id_pc, first_pc_exp);
                        want_first = 1'b0;
                    end
                end
                if (imem_resp_valid) begin
                    model_inflight--;
                    if (cur_resp.epoch == epoch) begin
                        sb_item.insn = mem_word(cur_resp.pc);
                        sb_item.pc   = cur_resp.pc;
                        sb.push_back(sb_item);
                    end
                end
                if (imem_req_valid && imem_req_ready) begin
                    check_output("req_addr", imem_req_addr, model_pc);
                    new_req.addr      = imem_req_addr;
                    new_req.pc        = model_pc;
                    new_req.epoch     = epoch;
                    new_req.ready_cyc = cyc + 1;
                    mem_q.push_back(new_req);
                    if (first_acc_cyc < 0) first_acc_cyc = cyc;
                    if (wrap_capture && (wrap_q.size() < 3)) wrap_q.push_back(imem_req_addr);
                    model_pc = model_pc + 32'd4;
                    model_inflight++;
                end
            end
        end
    end

    initial begin
        bit          f;
        bit          do_rst;
        int          rdy;
        int          idr;
        int          rsp;
        logic [31:0] rpc;
        logic [31:0] wrap_exp [3];

        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;

        apply_stimulus(1'b1, 0, 32'h0, 0, 0, 0, f);
        apply_stimulus(1'b1, 0, 32'h0, 0, 0, 0, f);

        // Streaming with everything ready: first word reaches decode two cycles after first accept.
        run_cycles(20, 100, 100, 100);
        check_output("fill_latency", 32'(first_idv_cyc - first_acc_cyc), 32'd2);

        // Decode stalls: buffer fills, requests stop, nothing is lost on release.
        run_cycles(10, 100, 0, 100);
        @(negedge clk);
        check_output("stall_req_valid", 32'(imem_req_valid), 32'd0);
        check_output("stall_id_valid", 32'(id_valid), 32'd1);
        run_cycles(10, 100, 100, 100);

        // Redirect to an unaligned target with two fetches outstanding.
        apply_stimulus(1'b1, 0, 32'h0, 0, 0, 0, f);
        run_cycles(3, 100, 100, 0);
        apply_stimulus(1'b0, 1, 32'h0000_0103, 100, 100, 0, f);
        first_pc_exp = 32'h0000_0100;
        want_first   = 1'b1;
        run_cycles(12, 100, 100, 100);
        check_output("redirect_first_seen", 32'(want_first), 32'd0);

        // Redirect in the same cycle as a pop and an arriving response.
        f = 1'b0;
        for (int i = 0; (i < 12) && !f; i++) begin
            apply_stimulus(1'b0, 2, 32'h0000_0200, 100, 100, 100, f);
        end
        check_output("pop_resp_redirect_setup", 32'(f), 32'd1);
        apply_stimulus(1'b0, 0, 32'h0, 100, 100, 0, f);
        @(negedge clk);
        check_output("empty_after_redirect", 32'(id_valid), 32'd0);
        run_cycles(8, 100, 100, 100);

        // PC wraps from the top of the address space back to zero.
        wrap_q.delete();
        apply_stimulus(1'b0, 1, 32'hFFFF_FFF8, 100, 100, 100, f);
        wrap_capture = 1'b1;
        run_cycles(12, 100, 100, 100);
        wrap_capture = 1'b0;
        check_output("wrap_count", 32'(wrap_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check_output("wrap_addr", (i < wrap_q.size()) ? wrap_q[i] : 32'hDEAD_BEEF, wrap_exp[i]);
        end

        // Reset with a full buffer: outputs clear and fetch restarts at the reset PC.
        run_cycles(10, 100, 0, 100);
        apply_stimulus(1'b1, 0, 32'h0, 100, 0, 100, f);
        apply_stimulus(1'b0, 0, 32'h0, 100, 100, 100, f);
        @(negedge clk);
        check_output("post_reset_id_valid", 32'(id_valid), 32'd0);
        check_output("post_reset_id_instruction", id_instruction, 32'd0);
        check_output("post_reset_id_pc", id_pc, 32'd0);
        check_output("post_reset_req_valid", 32'(imem_req_valid), 32'd1);
        check_output("post_reset_req_addr", imem_req_addr, RESET_PC);

        // Random traffic with varying ready rates, redirects and occasional resets.
        rdy = 100;
        idr = 100;
        rsp = 100;
        for (int i = 0; i < 3000; i++) begin
            if ((i % 50) == 0) begin
                rdy = int'($urandom_range(30, 100));
                idr = int'($urandom_range(20, 100));
                rsp = int'($urandom_range(30, 100));
            end
            do_rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 1) == 0) rpc = $urandom();
            else rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            apply_stimulus(do_rst, (!do_rst && ($urandom_range(0, 19) == 0)) ? 1 : 0, rpc, rdy, idr, rsp, f);
        end

        run_cycles(40, 100, 100, 100);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
